// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with held grants.
// Ports:
//   clk, rst_n (async active-low)
//   req[3:0], done (inputs)
//   gnt[3:0] one-hot, gnt_idx[1:0], gnt_valid, timeout (registered outputs)
// Build option: define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD
// cycles. Without it, timeout is tied low and no counter is built.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [1:0] ptr;

    logic       win_found;
    logic [1:0] win_idx;
    logic [3:0] win_oh;
    logic [1:0] cand;

    logic       rel_user;
    logic       release_now;
    logic       to_fire;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (2-bit add wraps mod 4);
    // the first active request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_oh = 4'b0000;
        unique case (win_idx)
            2'd0: win_oh = 4'b0001;
            2'd1: win_oh = 4'b0010;
            2'd2: win_oh = 4'b0100;
            2'd3: win_oh = 4'b1000;
            default: win_oh = 4'b0000;
        endcase
    end

    // Owner ends the transfer or drops its request; both together
    // still form one release.
    assign rel_user = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [3:0] hold_cnt;
    logic       hold_hit;

    assign hold_hit    = (state == GRANT) && (hold_cnt == HOLD_LAST);
    assign release_now = rel_user | hold_hit;
    // Only flag a timeout when nothing else would have released.
    assign to_fire     = hold_hit & ~rel_user;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 4'd0;
        end else if (state == IDLE) begin
            hold_cnt <= 4'd0;
        end else if (release_now) begin
            hold_cnt <= 4'd0;
        end else begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end
`else
    logic unused_hold;

    assign unused_hold = ^HOLD_LAST;
    assign release_now = rel_user;
    assign to_fire     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state     <= GRANT;
                        gnt       <= win_oh;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    // No preemption: other requests wait for release.
                    if (release_now) begin
                        state     <= IDLE;
                        ptr       <= gnt_idx + 2'd1;
                        gnt       <= 4'b0000;
                        gnt_idx   <= 2'b00;
                        gnt_valid <= 1'b0;
                        timeout   <= to_fire;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
